// File: rtl/mem_access_stage.sv
// Memory-access pipeline stage: drives the data-memory handshake, stalls upstream
// while an access is outstanding, and loads the MEM/WB register on the falling edge.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] ALUout_i,
    input  logic [31:0] ID_EX_B_i,
    input  logic [4:0]  EX_MUX_i,
    input  logic        MemRd_i,
    input  logic        MemWr_i,
    input  logic        MemtoReg_i,
    input  logic        RegWr_i,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i,
    output logic        stall_o,
    output logic [31:0] wb_data_o,
    output logic [4:0]  wb_rd_o,
    output logic        wb_RegWr_o,
    output logic        misalign_o,
    output logic        bus_err_o
);

    typedef enum logic {IDLE, BUSY} state_t;

    localparam logic [7:0] LP_TMO_LAST = 8'(TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nx;
    logic [7:0]  r_cnt;
    logic        r_memtoreg;
    logic [4:0]  r_rd;
    logic        r_regwr;

    logic        w_mem_op;
    logic        w_aligned;
    logic        w_timeout;
    logic        w_stall;
    logic        w_issue;
    logic        w_misalign;
    logic        w_done;
    logic        w_abort;

    assign w_mem_op  = MemRd_i | MemWr_i;
    assign w_aligned = (ALUout_i[1:0] == 2'b00);
    assign w_timeout = (r_cnt == LP_TMO_LAST);
    assign stall_o   = rst_i & w_stall;

    always_ff @(negedge clk_i) begin
        if (!rst_i) r_state <= IDLE;
        else        r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        w_stall    = 1'b0;
        w_issue    = 1'b0;
        w_misalign = 1'b0;
        w_done     = 1'b0;
        w_abort    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_mem_op) begin
                    if (w_aligned) begin
                        w_stall    = 1'b1;
                        w_issue    = 1'b1;
                        w_state_nx = BUSY;
                    end else begin
                        w_misalign = 1'b1;
                    end
                end
            end
            BUSY: begin
                // ack beats a coinciding timeout
                if (dmem_ack_i) begin
                    w_done     = 1'b1;
                    w_state_nx = IDLE;
                end else if (w_timeout) begin
                    w_abort    = 1'b1;
                    w_state_nx = IDLE;
                end else begin
                    w_stall    = 1'b1;
                end
            end
            default: w_state_nx = IDLE;
        endcase
    end

    always_ff @(negedge clk_i) begin
        if (!rst_i) begin
            r_cnt        <= 8'd0;
            r_memtoreg   <= 1'b0;
            r_rd         <= 5'd0;
            r_regwr      <= 1'b0;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            dmem_addr_o  <= 32'd0;
            dmem_wdata_o <= 32'd0;
            wb_data_o    <= 32'd0;
            wb_rd_o      <= 5'd0;
            wb_RegWr_o   <= 1'b0;
            misalign_o   <= 1'b0;
            bus_err_o    <= 1'b0;
        end else begin
            misalign_o <= w_misalign;
            bus_err_o  <= w_abort;
            if (w_issue) begin
                // a write suppresses read-data return even if MemRd is also set
                dmem_addr_o  <= ALUout_i;
                dmem_wdata_o <= ID_EX_B_i;
                dmem_we_o    <= MemWr_i;
                r_memtoreg   <= MemtoReg_i & ~MemWr_i;
                r_rd         <= EX_MUX_i;
                r_regwr      <= RegWr_i;
                dmem_req_o   <= 1'b1;
                r_cnt        <= 8'd0;
                wb_RegWr_o   <= 1'b0;
            end else if (r_state == IDLE) begin
                if (w_misalign) begin
                    wb_RegWr_o <= 1'b0;
                end else begin
                    wb_data_o  <= ALUout_i;
                    wb_rd_o    <= EX_MUX_i;
                    wb_RegWr_o <= RegWr_i;
                end
            end else if (w_done) begin
                dmem_req_o <= 1'b0;
                wb_data_o  <= r_memtoreg ? dmem_rdata_i : dmem_addr_o;
                wb_rd_o    <= r_rd;
                wb_RegWr_o <= r_regwr;
            end else if (w_abort) begin
                dmem_req_o <= 1'b0;
                wb_RegWr_o <= 1'b0;
            end else begin
                r_cnt      <= r_cnt + 8'd1;
                wb_RegWr_o <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage (TIMEOUT = 4); inputs change and outputs
// are sampled in the high phase, away from the falling active edge.
module tb_mem_access_stage;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic [31:0] ALUout_i, ID_EX_B_i;
    logic [4:0]  EX_MUX_i;
    logic        MemRd_i, MemWr_i, MemtoReg_i, RegWr_i;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o, dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;
    logic        stall_o;
    logic [31:0] wb_data_o;
    logic [4:0]  wb_rd_o;
    logic        wb_RegWr_o, misalign_o, bus_err_o;

    typedef struct {
        logic [31:0] data;
        logic [4:0]  rd;
        logic        regwr;
    } exp_t;

    exp_t sb[$];
    exp_t e;
    int   errors = 0;
    int   checks = 0;

    always #5 clk_i = ~clk_i;

    mem_access_stage #(.TIMEOUT(4)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .ALUout_i(ALUout_i), .ID_EX_B_i(ID_EX_B_i), .EX_MUX_i(EX_MUX_i),
        .MemRd_i(MemRd_i), .MemWr_i(MemWr_i), .MemtoReg_i(MemtoReg_i), .RegWr_i(RegWr_i),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o),
        .dmem_addr_o(dmem_addr_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
        .stall_o(stall_o),
        .wb_data_o(wb_data_o), .wb_rd_o(wb_rd_o), .wb_RegWr_o(wb_RegWr_o),
        .misalign_o(misalign_o), .bus_err_o(bus_err_o)
    );

    // one falling (active) edge, then settle into the next high phase
    task automatic step();
        @(negedge clk_i);
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [31:0] alu, input logic [31:0] b, input logic [4:0] rd,
                         input logic mrd, input logic mwr, input logic m2r, input logic rw);
        ALUout_i = alu; ID_EX_B_i = b; EX_MUX_i = rd;
        MemRd_i = mrd; MemWr_i = mwr; MemtoReg_i = m2r; RegWr_i = rw;
    endtask

    task automatic nop();
        drive(32'h0, 32'h0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_reset();
        rst_i = 1'b0;
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'h0;
        drive(32'h40, 32'h0, 5'd1, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_o); end
        step();
        checks++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o} !== 66'd0) begin
            errors++; $display("FAIL reset_bus got req=%b we=%b addr=%h wdata=%h exp all 0",
                               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o);
        end
        checks++;
        if ({wb_data_o, wb_rd_o, wb_RegWr_o, misalign_o, bus_err_o} !== 40'd0) begin
            errors++; $display("FAIL reset_wb got data=%h rd=%0d rw=%b mis=%b berr=%b exp all 0",
                               wb_data_o, wb_rd_o, wb_RegWr_o, misalign_o, bus_err_o);
        end
        nop();
        rst_i = 1'b1;
    endtask

    task automatic test_alu();
        drive(32'h0000_1234, 32'h0, 5'd5, 1'b0, 1'b0, 1'b0, 1'b1);
        sb.push_back('{32'h1234, 5'd5, 1'b1});
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL alu_stall got=%b exp=0", stall_o); end
        step();
        e = sb.pop_front();
        checks++;
        if (wb_data_o !== e.data || wb_rd_o !== e.rd || wb_RegWr_o !== e.regwr) begin
            errors++; $display("FAIL alu_wb got %h/%0d/%b exp %h/%0d/%b",
                               wb_data_o, wb_rd_o, wb_RegWr_o, e.data, e.rd, e.regwr);
        end
        checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL alu_req got=%b exp=0", dmem_req_o); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] a;
        logic [4:0]  r;
        logic        w;
        for (int i = 0; i < 6; i++) begin
            a = $urandom; r = 5'($urandom_range(0, 31)); w = 1'($urandom_range(0, 1));
            drive(a, $urandom, r, 1'b0, 1'b0, 1'($urandom_range(0, 1)), w);
            sb.push_back('{a, r, w});
            #1;
            checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL b2b_stall[%0d] got=%b exp=0", i, stall_o); end
            step();
            e = sb.pop_front();
            checks++;
            if (wb_data_o !== e.data || wb_rd_o !== e.rd || wb_RegWr_o !== e.regwr) begin
                errors++; $display("FAIL b2b_wb[%0d] got %h/%0d/%b exp %h/%0d/%b", i,
                                   wb_data_o, wb_rd_o, wb_RegWr_o, e.data, e.rd, e.regwr);
            end
        end
        nop();
    endtask

    // access acked in BUSY cycle n_ack; checks bus fields while requesting and the stall count
    task automatic run_access(input string nm, input logic [31:0] alu, input logic [31:0] b,
                              input logic [4:0] rd, input logic mrd, input logic mwr,
                              input logic m2r, input logic rw, input int n_ack,
                              input logic [31:0] rdata);
        int stalls = 0;
        drive(alu, b, rd, mrd, mwr, m2r, rw);
        sb.push_back('{(m2r && !mwr) ? rdata : alu, rd, rw});
        #1;
        if (stall_o) stalls++;
        step();
        for (int c = 1; c <= n_ack; c++) begin
            checks++;
            if (dmem_req_o !== 1'b1 || dmem_addr_o !== alu || dmem_we_o !== mwr ||
                (mwr && dmem_wdata_o !== b)) begin
                errors++; $display("FAIL %s_bus[%0d] got req=%b addr=%h we=%b wdata=%h exp req=1 addr=%h we=%b wdata=%h",
                                   nm, c, dmem_req_o, dmem_addr_o, dmem_we_o, dmem_wdata_o, alu, mwr, b);
            end
            checks++; if (wb_RegWr_o !== 1'b0) begin errors++; $display("FAIL %s_bubble[%0d] got=%b exp=0", nm, c, wb_RegWr_o); end
            dmem_ack_i   = (c == n_ack);
            dmem_rdata_i = (c == n_ack) ? rdata : 32'h1111_1111;
            #1;
            if (stall_o) stalls++;
            step();
        end
        dmem_ack_i = 1'b0;
        nop();
        checks++; if (stalls !== n_ack) begin errors++; $display("FAIL %s_stalls got=%0d exp=%0d", nm, stalls, n_ack); end
        checks++; if (dmem_req_o !== 1'b0) begin errors++; $display("FAIL %s_req_drop got=%b exp=0", nm, dmem_req_o); end
        e = sb.pop_front();
        checks++;
        if (wb_RegWr_o !== e.regwr || (e.regwr && (wb_data_o !== e.data || wb_rd_o !== e.rd))) begin
            errors++; $display("FAIL %s_wb got %h/%0d/%b exp %h/%0d/%b", nm,
                               wb_data_o, wb_rd_o, wb_RegWr_o, e.data, e.rd, e.regwr);
        end
    endtask

    task automatic test_load();
        run_access("load", 32'h40, 32'h0, 5'd7, 1'b1, 1'b0, 1'b1, 1'b1, 3, 32'hDEAD_BEEF);
    endtask

    task automatic test_store();
        run_access("store", 32'h80, 32'hCAFE, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1, 32'h0);
        run_access("rdwr", 32'h100, 32'h77, 5'd9, 1'b1, 1'b1, 1'b1, 1'b1, 2, 32'h55);
    endtask

    task automatic test_misalign();
        drive(32'h42, 32'h0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b1);
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL mis_stall got=%b exp=0", stall_o); end
        step();
        checks++;
        if (dmem_req_o !== 1'b0 || misalign_o !== 1'b1 || wb_RegWr_o !== 1'b0) begin
            errors++; $display("FAIL mis_edge got req=%b mis=%b rw=%b exp 0/1/0", dmem_req_o, misalign_o, wb_RegWr_o);
        end
        drive(32'h99, 32'h0, 5'd2, 1'b0, 1'b0, 1'b0, 1'b1);
        dmem_ack_i = 1'b1;
        step();
        dmem_ack_i = 1'b0;
        checks++; if (misalign_o !== 1'b0) begin errors++; $display("FAIL mis_pulse got=%b exp=0", misalign_o); end
        checks++;
        if (dmem_req_o !== 1'b0 || wb_data_o !== 32'h99 || wb_RegWr_o !== 1'b1) begin
            errors++; $display("FAIL idle_ack got req=%b data=%h rw=%b exp 0/00000099/1", dmem_req_o, wb_data_o, wb_RegWr_o);
        end
        nop();
    endtask

    task automatic test_timeout();
        int stalls = 0;
        drive(32'h44, 32'h0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1);
        step();
        for (int c = 1; c <= 4; c++) begin
            checks++; if (dmem_req_o !== 1'b1) begin errors++; $display("FAIL tmo_req[%0d] got=%b exp=1", c, dmem_req_o); end
            if (stall_o) stalls++;
            if (c == 4) begin
                checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL tmo_last_stall got=%b exp=0", stall_o); end
            end
            step();
        end
        nop();
        checks++; if (stalls !== 3) begin errors++; $display("FAIL tmo_stalls got=%0d exp=3", stalls); end
        checks++;
        if (dmem_req_o !== 1'b0 || bus_err_o !== 1'b1 || wb_RegWr_o !== 1'b0) begin
            errors++; $display("FAIL tmo_abort got req=%b berr=%b rw=%b exp 0/1/0", dmem_req_o, bus_err_o, wb_RegWr_o);
        end
        step();
        checks++; if (bus_err_o !== 1'b0) begin errors++; $display("FAIL tmo_pulse got=%b exp=0", bus_err_o); end
    endtask

    task automatic test_reset_mid();
        drive(32'h48, 32'h1234, 5'd6, 1'b0, 1'b1, 1'b0, 1'b1);
        step();
        step();
        rst_i = 1'b0;
        #1;
        checks++; if (stall_o !== 1'b0) begin errors++; $display("FAIL rstmid_stall got=%b exp=0", stall_o); end
        step();
        checks++;
        if ({dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, wb_data_o, wb_rd_o, wb_RegWr_o,
             misalign_o, bus_err_o} !== 106'd0) begin
            errors++; $display("FAIL rstmid_out got req=%b we=%b addr=%h wd=%h data=%h rd=%0d rw=%b exp all 0",
                               dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, wb_data_o, wb_rd_o, wb_RegWr_o);
        end
        rst_i = 1'b1;
        nop();
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF;
        step();
        dmem_ack_i = 1'b0;
        checks++;
        if (dmem_req_o !== 1'b0 || wb_RegWr_o !== 1'b0 || wb_data_o !== 32'h0) begin
            errors++; $display("FAIL rstmid_ack got req=%b rw=%b data=%h exp 0/0/00000000", dmem_req_o, wb_RegWr_o, wb_data_o);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_back_to_back();
        test_load();
        test_store();
        test_misalign();
        test_timeout();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
